// File: rtl/imm_rot_encoder_pkg.sv
// Shared types and defaults for the rotated-immediate encoder.
package imm_enc_pkg;

   localparam int unsigned DATA_W_DEF = 32;
   localparam int unsigned IMM_W_DEF  = 8;
   localparam int unsigned ROT_W_DEF  = 4;

   // Highest rotate index tried before declaring the value unencodable.
   localparam int unsigned LAST_ROT = (2 ** ROT_W_DEF) - 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEARCH = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/imm_rot_encoder_rot_fit_check.sv
// Tests one rotation candidate: rotates value left by 2*r and reports whether it fits in IMM_W bits.
module rot_fit_check
   import imm_enc_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IMM_W  = IMM_W_DEF,
   parameter int unsigned ROT_W  = ROT_W_DEF
) (
   input  logic [DATA_W-1:0] value,
   input  logic [ROT_W-1:0]  r,
   output logic [DATA_W-1:0] cand,
   output logic              fit
);

   logic [2*DATA_W-1:0] doubled;

   // Left rotate via a doubled word: the upper half after shifting is the rotation.
   always_comb begin
      doubled = {value, value} << {r, 1'b0};
      cand    = doubled[2*DATA_W-1:DATA_W];
      fit     = ~|cand[DATA_W-1:IMM_W];
   end

endmodule

// File: rtl/imm_rot_encoder.sv
// Multi-cycle search for the {rot4, imm8} immediate form of a 32-bit constant, one rotation per clock.
module imm_rot_encoder
   import imm_enc_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned IMM_W  = IMM_W_DEF,
   parameter int unsigned ROT_W  = ROT_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] value,
   input  logic              c_in,
   output logic              busy,
   output logic              done,
   output logic              encodable,
   output logic [IMM_W-1:0]  imm8,
   output logic [ROT_W-1:0]  rot4,
   output logic [11:0]       operand12,
   output logic              carry_out
);

   state_t              state;
   logic [ROT_W-1:0]    r;
   logic [DATA_W-1:0]   val_q;
   logic                c_q;
   logic [DATA_W-1:0]   cand;
   logic                fit;

   rot_fit_check #(
      .DATA_W (DATA_W),
      .IMM_W  (IMM_W),
      .ROT_W  (ROT_W)
   ) u_fit (
      .value (val_q),
      .r     (r),
      .cand  (cand),
      .fit   (fit)
   );

   assign operand12 = {rot4, imm8};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         r         <= '0;
         val_q     <= '0;
         c_q       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         encodable <= 1'b0;
         imm8      <= '0;
         rot4      <= '0;
         carry_out <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  val_q <= value;
                  c_q   <= c_in;
                  r     <= '0;
                  busy  <= 1'b1;
                  state <= SEARCH;
               end
            end
            SEARCH: begin
               if (fit) begin
                  encodable <= 1'b1;
                  imm8      <= IMM_W'(cand);
                  rot4      <= r;
                  // Non-zero rotation exposes the rotated MSB as the shifter carry.
                  carry_out <= (r == '0) ? c_q : val_q[DATA_W-1];
                  done      <= 1'b1;
                  state     <= DONE;
               end else if (r == ROT_W'(LAST_ROT)) begin
                  encodable <= 1'b0;
                  imm8      <= '0;
                  rot4      <= '0;
                  carry_out <= c_q;
                  done      <= 1'b1;
                  state     <= DONE;
               end else begin
                  r <= r + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
